onchip_memory_arbiter: RTL and testbench
========================================

# onchip_memory_arbiter

Round-robin arbiter that shares the single-port 32-bit on-chip memory (50000 words, 16-bit word address, byte enables, 1-cycle read latency) between two Avalon-MM requesters: port 0 (Nios II data master) and port 1 (display refresh reader). It sits directly in front of the memory's s1 slave. It issues at most one access per cycle and returns read data to the issuing port with a registered valid strobe.

## Interface
Parameters:
- ADDR_W, 16, word address width on all ports
- DATA_W, 32, data width; byte enable width is DATA_W/8
- MEM_WORDS, 50000, highest legal address + 1; accesses at or above it are dropped

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- p0_address / p1_address  in  ADDR_W  word address
- p0_byteenable / p1_byteenable  in  DATA_W/8  byte lanes for writes
- p0_read / p1_read  in  1  read request
- p0_write / p1_write  in  1  write request
- p0_writedata / p1_writedata  in  DATA_W  write data
- p0_waitrequest / p1_waitrequest  out  1  request not accepted this cycle
- p0_readdata / p1_readdata  out  DATA_W  read data
- p0_readdatavalid / p1_readdatavalid  out  1  readdata valid this cycle
- mem_address  out  ADDR_W  to memory address
- mem_byteenable  out  DATA_W/8  to memory byteenable
- mem_chipselect  out  1  to memory chipselect
- mem_write  out  1  to memory write
- mem_writedata  out  DATA_W  to memory writedata
- mem_readdata  in  DATA_W  from memory readdata, valid 1 cycle after address
- err_oob  out  1  sticky: an out-of-range access was dropped

## Operation
- reqN = pN_read | pN_write. A port asserting both read and write in the same cycle is treated as a write.
- The arbiter state is a single register last_grant (0 or 1), reset value 1, so port 0 wins the first contention.
- Grant (combinational):
  - Only one port requests: that port is granted.
  - Both request: the port != last_grant is granted.
  - last_grant updates to the granted port on every grant.
- Granted port: pN_waitrequest = 0. The mem_* outputs carry its address, byteenable and writedata, with mem_chipselect = 1 and mem_write = the write flag.
- Non-granted requesting port: pN_waitrequest = 1. It must hold its request stable until accepted.
- Idle port: waitrequest = 0. Idle cycle: mem_chipselect = 0, mem_write = 0.
- Accepted read: the registers rd_pend (1 bit) and rd_port (1 bit) are set. On the next cycle, p[rd_port]_readdatavalid = 1 and p[rd_port]_readdata = mem_readdata.
- Both readdata outputs are driven by mem_readdata; only readdatavalid is steered.
- Out-of-range request (address >= MEM_WORDS):
  - Accepted normally (waitrequest = 0) and counts as a grant.
  - mem_chipselect = 0.
  - A read still returns readdatavalid with readdata = 0.
  - err_oob is set and stays set until reset.
- No read queue exists: latency is fixed, so at most one read is in flight, and back-to-back reads retire one per cycle.

## Timing
- Throughput: one accepted access per cycle. Under continuous contention the grant alternates 0,1,0,1.
- Read latency: accept in cycle N, then readdatavalid and data in cycle N+1.
- Write takes effect in the memory at the accepting clock edge. A read to the same address accepted in the next cycle returns the new data.
- waitrequest is a combinational function of reqN and last_grant, and does not depend on readdatavalid.
- Reset values: last_grant = 1, rd_pend = 0, rd_port = 0, both readdatavalid = 0, err_oob = 0. While reset_n = 0, all mem_* controls are 0 and both waitrequest = 0.
- Reset asserted mid-read: the pending readdatavalid is cancelled, and no strobe appears after reset_n rises.
- A port's request in the same cycle as its own readdatavalid is legal and arbitrated normally.

## Test plan
- Single port 0 write: addr 0x0010 ← 0xDEADBEEF, be=0xF. Then read 0x0010. Expect waitrequest = 0 both cycles, p0_readdatavalid one cycle after accept with 0xDEADBEEF, and p1_readdatavalid = 0.
- Byte enables: write 0x11223344 with be=0xF, then 0xAA000000 with be=0x8, then read. Expect 0xAA223344.
- Contention: both ports read continuously for 8 cycles from reset, p0 at 0x0100, p1 at 0x0200. Expect grants 0,1,0,1,… with waitrequest toggling, and each readdatavalid delivered to the correct port with its own data.
- Back-to-back: port 1 alone reads 4 consecutive addresses. Expect 4 accepts in 4 cycles and 4 consecutive readdatavalid pulses, each lagging by 1 cycle.
- Out of range: p0 reads address 50000. Expect mem_chipselect = 0, readdatavalid with readdata 0, and err_oob = 1 held until reset_n is pulsed.
- Reset mid-read: assert reset_n = 0 in the cycle after a read is accepted. Expect no readdatavalid, last_grant = 1, and all outputs at their reset values.

Source files
------------

// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter sharing a single-port on-chip memory between two Avalon-MM requesters.
// One access per cycle; read data returns one cycle after accept; the losing requester sees waitrequest.
module onchip_memory_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   p0_address,
  input  logic [DATA_W/8-1:0] p0_byteenable,
  input  logic                p0_read,
  input  logic                p0_write,
  input  logic [DATA_W-1:0]   p0_writedata,
  output logic                p0_waitrequest,
  output logic [DATA_W-1:0]   p0_readdata,
  output logic                p0_readdatavalid,
  input  logic [ADDR_W-1:0]   p1_address,
  input  logic [DATA_W/8-1:0] p1_byteenable,
  input  logic                p1_read,
  input  logic                p1_write,
  input  logic [DATA_W-1:0]   p1_writedata,
  output logic                p1_waitrequest,
  output logic [DATA_W-1:0]   p1_readdata,
  output logic                p1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err_oob
);

  localparam logic [ADDR_W:0] LP_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  logic                r_last_grant;
  logic                r_rd_pend;
  logic                r_rd_port;
  logic                r_rd_oob;
  logic                r_err_oob;

  logic                w_req0;
  logic                w_req1;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_gnt;
  logic                w_sel;
  logic                w_wr;
  logic                w_oob;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W/8-1:0] w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;

  assign w_req0 = p0_read | p0_write;
  assign w_req1 = p1_read | p1_write;

  // Grants are suppressed while in reset so the memory sees no traffic.
  assign w_gnt0 = reset_n & w_req0 & (~w_req1 | r_last_grant);
  assign w_gnt1 = reset_n & w_req1 & (~w_req0 | ~r_last_grant);
  assign w_gnt  = w_gnt0 | w_gnt1;
  assign w_sel  = w_gnt1;

  always_comb begin
    w_addr  = p0_address;
    w_be    = p0_byteenable;
    w_wdata = p0_writedata;
    w_wr    = p0_write;
    if (w_sel) begin
      w_addr  = p1_address;
      w_be    = p1_byteenable;
      w_wdata = p1_writedata;
      w_wr    = p1_write;
    end
  end

  assign w_oob = ({1'b0, w_addr} >= LP_LIMIT);

  assign p0_waitrequest = reset_n & w_req0 & ~w_gnt0;
  assign p1_waitrequest = reset_n & w_req1 & ~w_gnt1;

  assign mem_chipselect = w_gnt & ~w_oob;
  assign mem_write      = mem_chipselect & w_wr;
  assign mem_address    = w_gnt ? w_addr  : '0;
  assign mem_byteenable = w_gnt ? w_be    : '0;
  assign mem_writedata  = w_gnt ? w_wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_rd_pend    <= 1'b0;
      r_rd_port    <= 1'b0;
      r_rd_oob     <= 1'b0;
      r_err_oob    <= 1'b0;
    end else begin
      r_rd_pend <= w_gnt & ~w_wr;
      if (w_gnt) begin
        r_last_grant <= w_sel;
      end
      if (w_gnt & ~w_wr) begin
        r_rd_port <= w_sel;
        r_rd_oob  <= w_oob;
      end
      if (w_gnt & w_oob) begin
        r_err_oob <= 1'b1;
      end
    end
  end

  // A dropped read never reached the memory, so its data is forced to zero.
  assign w_rdata          = r_rd_oob ? '0 : mem_readdata;
  assign p0_readdata      = w_rdata;
  assign p1_readdata      = w_rdata;
  assign p0_readdatavalid = r_rd_pend & ~r_rd_port;
  assign p1_readdatavalid = r_rd_pend & r_rd_port;
  assign err_oob          = r_err_oob;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed bench for onchip_memory_arbiter with a behavioural 1-cycle-latency memory behind it.
module tb_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] p0_address = '0, p1_address = '0;
  logic [3:0]  p0_byteenable = '0, p1_byteenable = '0;
  logic        p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
  logic [31:0] p0_writedata = '0, p1_writedata = '0;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        err_oob;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mem_arr [0:49999];

  always #5 clk = ~clk;

  onchip_memory_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_WORDS(50000)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
    .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
    .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
    .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
    .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .err_oob(err_oob)
  );

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_arr[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= mem_arr[mem_address];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_p0(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    p0_read = rd; p0_write = wr; p0_address = a; p0_byteenable = be; p0_writedata = d;
  endtask

  task automatic drive_p1(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    p1_read = rd; p1_write = wr; p1_address = a; p1_byteenable = be; p1_writedata = d;
  endtask

  task automatic idle_all();
    drive_p0(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drive_p1(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
  endtask

  task automatic pulse_reset();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_p0(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    drive_p1(1'b0, 1'b1, 16'h0020, 4'hF, 32'h1234);
    @(negedge clk);
    n_total++; if (mem_chipselect !== 1'b0) $display("FAIL rst_cs: got %b want 0", mem_chipselect); else n_pass++;
    n_total++; if (mem_write !== 1'b0) $display("FAIL rst_wr: got %b want 0", mem_write); else n_pass++;
    n_total++; if ({p0_waitrequest, p1_waitrequest} !== 2'b00) $display("FAIL rst_wait: got %b want 00", {p0_waitrequest, p1_waitrequest}); else n_pass++;
    n_total++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00) $display("FAIL rst_rdv: got %b want 00", {p0_readdatavalid, p1_readdatavalid}); else n_pass++;
    n_total++; if (err_oob !== 1'b0) $display("FAIL rst_oob: got %b want 0", err_oob); else n_pass++;
    idle_all();
    step();
    reset_n = 1'b1;
  endtask

  task automatic preload();
    drive_p0(1'b0, 1'b1, 16'h0100, 4'hF, 32'hA0A0_0100);
    step();
    drive_p0(1'b0, 1'b1, 16'h0200, 4'hF, 32'hB0B0_0200);
    for (int i = 0; i < 4; i++) begin
      step();
      drive_p0(1'b0, 1'b1, 16'h0300 + 16'(i), 4'hF, 32'hC000_0000 + 32'(i));
    end
    step();
    idle_all();
  endtask

  task automatic test_contention();
    logic [31:0] exp_d;
    drive_p0(1'b1, 1'b0, 16'h0100, 4'hF, 32'h0);
    drive_p1(1'b1, 1'b0, 16'h0200, 4'hF, 32'h0);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) idle_all();
      @(negedge clk);
      if (i < 8) begin
        n_total++; if (p0_waitrequest !== (i % 2 == 1)) $display("FAIL cont_w0[%0d]: got %b want %b", i, p0_waitrequest, (i % 2 == 1)); else n_pass++;
        n_total++; if (p1_waitrequest !== (i % 2 == 0)) $display("FAIL cont_w1[%0d]: got %b want %b", i, p1_waitrequest, (i % 2 == 0)); else n_pass++;
        n_total++; if (mem_address !== ((i % 2 == 0) ? 16'h0100 : 16'h0200)) $display("FAIL cont_addr[%0d]: got %h", i, mem_address); else n_pass++;
      end
      if (i > 0) begin
        exp_d = ((i - 1) % 2 == 0) ? 32'hA0A0_0100 : 32'hB0B0_0200;
        n_total++; if (p0_readdatavalid !== ((i - 1) % 2 == 0)) $display("FAIL cont_v0[%0d]: got %b", i, p0_readdatavalid); else n_pass++;
        n_total++; if (p1_readdatavalid !== ((i - 1) % 2 == 1)) $display("FAIL cont_v1[%0d]: got %b", i, p1_readdatavalid); else n_pass++;
        n_total++; if (((i - 1) % 2 == 0 ? p0_readdata : p1_readdata) !== exp_d) $display("FAIL cont_data[%0d]: got %h want %h", i, ((i - 1) % 2 == 0 ? p0_readdata : p1_readdata), exp_d); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_single_write_read();
    drive_p0(1'b0, 1'b1, 16'h0010, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    n_total++; if (p0_waitrequest !== 1'b0) $display("FAIL wr_wait: got %b want 0", p0_waitrequest); else n_pass++;
    n_total++; if ({mem_chipselect, mem_write} !== 2'b11) $display("FAIL wr_ctl: got %b want 11", {mem_chipselect, mem_write}); else n_pass++;
    step();
    drive_p0(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    @(negedge clk);
    n_total++; if (p0_waitrequest !== 1'b0) $display("FAIL rd_wait: got %b want 0", p0_waitrequest); else n_pass++;
    n_total++; if ({mem_chipselect, mem_write} !== 2'b10) $display("FAIL rd_ctl: got %b want 10", {mem_chipselect, mem_write}); else n_pass++;
    n_total++; if (p0_readdatavalid !== 1'b0) $display("FAIL rd_early: got %b want 0", p0_readdatavalid); else n_pass++;
    step();
    idle_all();
    @(negedge clk);
    n_total++; if (p0_readdatavalid !== 1'b1) $display("FAIL rd_v0: got %b want 1", p0_readdatavalid); else n_pass++;
    n_total++; if (p0_readdata !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", p0_readdata); else n_pass++;
    n_total++; if (p1_readdatavalid !== 1'b0) $display("FAIL rd_v1: got %b want 0", p1_readdatavalid); else n_pass++;
    step();
    @(negedge clk);
    n_total++; if (p0_readdatavalid !== 1'b0) $display("FAIL rd_once: got %b want 0", p0_readdatavalid); else n_pass++;
    step();
  endtask

  task automatic test_byte_enables();
    drive_p0(1'b0, 1'b1, 16'h0020, 4'hF, 32'h1122_3344);
    step();
    drive_p0(1'b0, 1'b1, 16'h0020, 4'h8, 32'hAA00_0000);
    step();
    drive_p0(1'b1, 1'b0, 16'h0020, 4'hF, 32'h0);
    step();
    idle_all();
    @(negedge clk);
    n_total++; if (p0_readdatavalid !== 1'b1) $display("FAIL be_v: got %b want 1", p0_readdatavalid); else n_pass++;
    n_total++; if (p0_readdata !== 32'hAA22_3344) $display("FAIL be_data: got %h want aa223344", p0_readdata); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_p1(1'b1, 1'b0, 16'h0300 + 16'(i), 4'hF, 32'h0);
      else idle_all();
      @(negedge clk);
      if (i < 4) begin
        n_total++; if (p1_waitrequest !== 1'b0) $display("FAIL b2b_wait[%0d]: got %b want 0", i, p1_waitrequest); else n_pass++;
      end
      n_total++; if (p1_readdatavalid !== (i > 0)) $display("FAIL b2b_v[%0d]: got %b want %b", i, p1_readdatavalid, (i > 0)); else n_pass++;
      if (i > 0) begin
        n_total++; if (p1_readdata !== 32'hC000_0000 + 32'(i - 1)) $display("FAIL b2b_data[%0d]: got %h want %h", i, p1_readdata, 32'hC000_0000 + 32'(i - 1)); else n_pass++;
      end
      n_total++; if (p0_readdatavalid !== 1'b0) $display("FAIL b2b_v0[%0d]: got %b want 0", i, p0_readdatavalid); else n_pass++;
      step();
    end
  endtask

  task automatic test_oob();
    @(negedge clk);
    n_total++; if (err_oob !== 1'b0) $display("FAIL oob_pre: got %b want 0", err_oob); else n_pass++;
    step();
    drive_p0(1'b1, 1'b0, 16'd50000, 4'hF, 32'h0);
    @(negedge clk);
    n_total++; if (mem_chipselect !== 1'b0) $display("FAIL oob_cs: got %b want 0", mem_chipselect); else n_pass++;
    n_total++; if (p0_waitrequest !== 1'b0) $display("FAIL oob_wait: got %b want 0", p0_waitrequest); else n_pass++;
    step();
    idle_all();
    @(negedge clk);
    n_total++; if (p0_readdatavalid !== 1'b1) $display("FAIL oob_v: got %b want 1", p0_readdatavalid); else n_pass++;
    n_total++; if (p0_readdata !== 32'h0) $display("FAIL oob_data: got %h want 0", p0_readdata); else n_pass++;
    n_total++; if (err_oob !== 1'b1) $display("FAIL oob_flag: got %b want 1", err_oob); else n_pass++;
    step(); step(); step();
    @(negedge clk);
    n_total++; if (err_oob !== 1'b1) $display("FAIL oob_sticky: got %b want 1", err_oob); else n_pass++;
    pulse_reset();
    @(negedge clk);
    n_total++; if (err_oob !== 1'b0) $display("FAIL oob_clear: got %b want 0", err_oob); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_read();
    drive_p1(1'b0, 1'b1, 16'h0040, 4'hF, 32'h5555_AAAA);
    step();
    drive_p1(1'b1, 1'b0, 16'h0040, 4'hF, 32'h0);
    step();
    reset_n = 1'b0;
    drive_p0(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    drive_p1(1'b1, 1'b0, 16'h0040, 4'hF, 32'h0);
    @(negedge clk);
    n_total++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00) $display("FAIL mid_rdv: got %b want 00", {p0_readdatavalid, p1_readdatavalid}); else n_pass++;
    n_total++; if ({mem_chipselect, mem_write} !== 2'b00) $display("FAIL mid_ctl: got %b want 00", {mem_chipselect, mem_write}); else n_pass++;
    n_total++; if ({p0_waitrequest, p1_waitrequest} !== 2'b00) $display("FAIL mid_wait: got %b want 00", {p0_waitrequest, p1_waitrequest}); else n_pass++;
    step();
    idle_all();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++; if ({p0_readdatavalid, p1_readdatavalid} !== 2'b00) $display("FAIL mid_post[%0d]: got %b want 00", i, {p0_readdatavalid, p1_readdatavalid}); else n_pass++;
      step();
    end
    drive_p0(1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    drive_p1(1'b1, 1'b0, 16'h0040, 4'hF, 32'h0);
    @(negedge clk);
    n_total++; if ({p0_waitrequest, p1_waitrequest} !== 2'b01) $display("FAIL mid_lastgnt: got %b want 01", {p0_waitrequest, p1_waitrequest}); else n_pass++;
    step();
    idle_all();
    step();
  endtask

  initial begin
    test_reset();
    preload();
    pulse_reset();
    test_contention();
    test_single_write_read();
    test_byte_enables();
    test_back_to_back();
    test_oob();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
